// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI receive path.
package midi_pkg;

  // Receive deframer states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  localparam logic [7:0] MIDI_RT_MIN      = 8'hF8;
  localparam logic [7:0] MIDI_STATUS_MASK = 8'h80;

  // System real-time messages occupy the top of the status byte range.
  function automatic logic is_rt(input logic [7:0] b);
    return ((b & MIDI_STATUS_MASK) != 8'h00) && (b >= MIDI_RT_MIN);
  endfunction

endpackage

// File: rtl/midi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with level/full/empty flags.
// Pointers carry one extra MSB so full and empty can be told apart.
module midi_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_ok, rd_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is only accepted when the head leaves in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents are masked by empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/midi_rx_buf.sv
// MIDI/UART serial receiver feeding an on-chip FIFO, with sticky error flags
// and a registered interrupt. Define MIDI_RX_RT_FILTER_EN to drop system
// real-time bytes (0xF8..0xFF) before they reach the FIFO.
module midi_rx_buf
  import midi_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_THRESH = 1,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_en,
  input  logic                 midi_in,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic [LW-1:0]        level,
  output logic                 busy,
  output logic                 ovr_err,
  output logic                 frm_err,
  output logic                 irq
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TickHalf = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TickLast = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BitLast  = BW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push, frm_set, rt_drop, push_ok, ovr_set;
  logic                 ovr_q, frm_q, irq_q;

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], midi_in};
  end
  assign rx_s = sync_q[1];

  // Deframer state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Deframer next state: advances only on sample ticks, samples each bit mid-way.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    frm_set = 1'b0;
    if (sample_en) begin
      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end
        StStart: begin
          if (tick_q == TickHalf) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? StIdle : StData;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StData: begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BitLast) state_d = StStop;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StStop: begin
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (rx_s) begin
              push    = 1'b1;
              state_d = StIdle;
            end else begin
              frm_set = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        StBreak: begin
          if (rx_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef MIDI_RX_RT_FILTER_EN
  logic [8:0] byte_ext;
  assign byte_ext = 9'(shift_q);
  assign rt_drop  = (DATA_BITS == 8) && is_rt(byte_ext[7:0]);
`else
  assign rt_drop = 1'b0;
`endif

  assign push_ok = push && !rt_drop;
  assign ovr_set = push_ok && full && !(rd_en && !empty);
  assign busy    = (state_q != StIdle);

  midi_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push_ok),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  // Sticky error flags (set wins over clear) and registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (ovr_set)      ovr_q <= 1'b1;
      else if (err_clr) ovr_q <= 1'b0;
      if (frm_set)      frm_q <= 1'b1;
      else if (err_clr) frm_q <= 1'b0;
      irq_q <= (level >= LW'(IRQ_THRESH)) | ovr_q | frm_q;
    end
  end

  assign ovr_err = ovr_q;
  assign frm_err = frm_q;
  assign irq     = irq_q;

endmodule
